nes_joypad_port: RTL and testbench
==================================

Name: nes_joypad_port

Overview:
CPU-bus responder for the NES controller registers $4016/$4017. It answers the 6502 core's memory reads and writes (addr, dout, mr, mw, ce) with serial controller data, exactly as the console does. Internally it polls two physical NES pads over their native latch/clock/data serial interface and keeps an atomic 8-bit snapshot per pad. It sits on the CPU data-bus mux beside RAM, PPU and APU.

Parameters:
CLK_DIV, 96, clk cycles per pad-serial half-bit; must be ≥2.
POLL_CYCLES, 16'd20000, idle clk cycles between the end of one poll and the next latch.
BASE, 16'h4016, address of port 1; port 2 is BASE+1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ce  in  1  CPU clock enable; bus accesses are qualified by ce
addr  in  16  CPU address bus (aout)
wdata  in  8  CPU write data (dout)
mr  in  1  CPU read strobe
mw  in  1  CPU write strobe
rdata  out  8  read data to the CPU DIN mux
rdata_en  out  1  high while rdata holds a value from this block (mux select)
pad_latch  out  1  latch line to both pads, active-high
pad_clk  out  1  clock line to both pads, idle high
pad_data  in  2  serial data from pad1 (bit0) and pad2 (bit1), active-low

Behaviour:
- Reset is synchronous and active-high on clk.
- Reset values: rdata=0, rdata_en=0, pad_latch=0, pad_clk=1, strobe=0, shift1/shift2=0, snap1/snap2=0, poller FSM=IDLE, counters=0.
- Button order, LSB first: A, B, Select, Start, Up, Down, Left, Right. snapN[i] = 1 means button i is pressed.
- Decode: sel1 = (addr==BASE), sel2 = (addr==BASE+1). A bus event occurs only on a cycle with ce=1.
- Write: ce & mw & sel1 sets strobe <= wdata[0]. Writes to BASE+1 are ignored; the APU owns that address.
- Strobe high: on every ce cycle shift1<=snap1 and shift2<=snap2, so reads keep returning the current A button.
- Strobe high→low: the shift registers keep the last loaded value.
- Read: ce & mr & (sel1|sel2) sets rdata <= {8'h40 | shiftN[0]} (open-bus bit 6 set) and rdata_en <= 1.
- Read latency: data is registered on the ce edge of the access and held until the next ce edge. On any ce cycle without a decoded read, rdata_en <= 0 and rdata keeps its value.
- Shift on read: if strobe=0, a read of port N also does shiftN <= {1'b1, shiftN[7:1]}. After 8 reads, every further read returns bit 1.
- If strobe=1, reads do not shift.
- Reads of one port never shift the other port.
- Poller FSM, running on clk and independent of ce:
  - IDLE → LATCH: pad_latch=1 for 2·CLK_DIV cycles.
  - LATCH → SAMPLE: at the end of LATCH, pad_latch<=0 and bit0 = ~pad_data is captured.
  - SHIFT_LO / SHIFT_HI, bits 1..7: pad_clk=0 for CLK_DIV cycles, then pad_clk=1 for CLK_DIV cycles. ~pad_data is sampled on the clk edge where pad_clk rises.
  - After bit 7 → COMMIT: for one cycle, snap1/snap2 <= the assembled bytes, both updated together.
  - COMMIT → WAIT: POLL_CYCLES cycles, then → IDLE.
- Snapshot update vs strobe reload in the same cycle: the reload takes the pre-commit snap. The new value appears on the next ce.
- Reset mid-poll: the FSM aborts to IDLE, pad lines return to their idle levels and any partial byte is discarded.
- Reset mid-access: rdata_en=0 on the following cycle.
- pad_data is double-flop synchronised before use. This adds 2 cycles of sampling delay, which is covered by the CLK_DIV ≥ 2 margin.

Decomposition:
- Shared package nes_io_pkg:
  - localparams JOY1_ADDR=16'h4016, JOY2_ADDR=16'h4017.
  - button bit indices BTN_A..BTN_RIGHT.
  - poller state enum {IDLE, LATCH, SHIFT_LO, SHIFT_HI, COMMIT, WAIT}.
- One sub-module, nes_pad_poller:
  - contains the FSM, the divider, the synchroniser and the snapshot registers.
  - outputs snap1 [7:0] and snap2 [7:0] to the bus front end.

Test Plan:
- Reset, then hold pad model pad1 = 8'b1111_1110 (A pressed, active-low) and pad2 = all released; wait one poll → snap1=8'h01, snap2=8'h00, and pad_latch high for exactly 2·CLK_DIV cycles.
- Write $4016=1, then $4016=0, then 10 reads of $4016 with pad1 = A+Start pressed → rdata sequence 41,40,40,41,40,40,40,40,41,41, with rdata_en=1 on each read's following ce window only.
- Strobe held at 1, 3 reads of $4017 with pad2 Right pressed → each read returns 8'h40; no shifting.
- Interleave reads of $4016 and $4017 after strobe → each port's bit sequence is unaffected by the other's reads.
- A write of 8'h01 to $4017 → strobe remains 0 and the shift registers are unchanged.
- Assert reset during SHIFT_LO of bit 4 → next cycle pad_clk=1, pad_latch=0, snap1/snap2 = 0, and a fresh poll starts from LATCH.

Source files
------------

// File: rtl/nes_io_pkg.sv
// nes_io_pkg: shared addresses, button bit indices and poller states for the NES controller port.
package nes_io_pkg;
    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, COMMIT, WAIT} poll_state_t;
endpackage

// File: rtl/nes_pad_poller.sv
// nes_pad_poller: polls two NES pads over latch/clock/data and keeps an atomic byte snapshot per pad.
// Ports: clk, reset (sync, active-high); pad_data[1:0] serial in (active-low);
//        pad_latch, pad_clk serial control out; snap1/snap2 pressed-button bytes (1 = pressed).
module nes_pad_poller
    import nes_io_pkg::*;
#(
    parameter int          CLK_DIV     = 96,
    parameter logic [15:0] POLL_CYCLES = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] snap1,
    output logic [7:0] snap2
);
    poll_state_t state, state_nxt;
    logic [15:0] cnt, lim;
    logic [2:0]  bit_idx;
    logic [1:0]  s0, s1;
    logic [7:0]  b1, b2;
    logic        done, sample;

    always_comb begin
        lim = state == LATCH ? 16'(2 * CLK_DIV) :
              (state == SHIFT_LO || state == SHIFT_HI) ? 16'(CLK_DIV) :
              state == WAIT ? POLL_CYCLES : 16'd1;
        done = (cnt + 16'd1) >= lim;
        // pad_clk rises on the edge that ends SHIFT_LO, which is also the sampling edge
        sample = (state == LATCH || state == SHIFT_LO) && done;
        pad_latch = state == LATCH;
        pad_clk = state != SHIFT_LO;
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = LATCH;
            LATCH:    state_nxt = done ? SHIFT_LO : LATCH;
            SHIFT_LO: state_nxt = done ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_nxt = done ? (bit_idx == 3'd7 ? COMMIT : SHIFT_LO) : SHIFT_HI;
            COMMIT:   state_nxt = WAIT;
            WAIT:     state_nxt = done ? IDLE : WAIT;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            s0      <= 2'b11;
            s1      <= 2'b11;
            b1      <= '0;
            b2      <= '0;
            snap1   <= '0;
            snap2   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= state_nxt != state ? 16'd0 : cnt + 16'd1;
            s0      <= pad_data;
            s1      <= s0;
            bit_idx <= state == LATCH ? 3'd1 : (state == SHIFT_HI && done) ? bit_idx + 3'd1 : bit_idx;
            // bits enter at the MSB so the first one (A) ends up in bit 0 after eight samples
            if (sample) begin
                b1 <= {~s1[0], b1[7:1]};
                b2 <= {~s1[1], b2[7:1]};
            end
            if (state == COMMIT) begin
                snap1 <= b1;
                snap2 <= b2;
            end
        end
    end
endmodule

// File: rtl/nes_joypad_port.sv
// nes_joypad_port: CPU-bus responder for $4016/$4017 returning serial controller data like the console.
// Ports: clk, reset (sync, active-high); ce, addr, wdata, mr, mw CPU bus in;
//        rdata/rdata_en to the CPU data mux; pad_latch, pad_clk, pad_data to the two pads.
module nes_joypad_port
    import nes_io_pkg::*;
#(
    parameter int          CLK_DIV     = 96,
    parameter logic [15:0] POLL_CYCLES = 16'd20000,
    parameter logic [15:0] BASE        = JOY1_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        mr,
    input  logic        mw,
    output logic [7:0]  rdata,
    output logic        rdata_en,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [1:0]  pad_data
);
    logic [7:0] snap1, snap2, shift1, shift2;
    logic       strobe, sel1, sel2, rd;

    assign sel1 = addr == BASE;
    assign sel2 = addr == BASE + 16'd1;
    assign rd   = mr & (sel1 | sel2);

    nes_pad_poller #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES)) u_poll (
        .clk(clk), .reset(reset), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .snap1(snap1), .snap2(snap2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            rdata_en <= 1'b0;
            strobe   <= 1'b0;
            shift1   <= '0;
            shift2   <= '0;
        end else if (ce) begin
            rdata_en <= rd;
            // bit 6 reflects open-bus residue of the upper address byte
            if (rd)
                rdata <= 8'h40 | {7'b0, sel1 ? shift1[BTN_A] : shift2[BTN_A]};
            if (mw && sel1)
                strobe <= wdata[0];
            shift1 <= strobe ? snap1 : (rd && sel1) ? {1'b1, shift1[7:1]} : shift1;
            shift2 <= strobe ? snap2 : (rd && sel2) ? {1'b1, shift2[7:1]} : shift2;
        end
    end
endmodule

// File: tb/tb_nes_joypad_port.sv
// tb_nes_joypad_port: directed self-checking bench for nes_joypad_port with a behavioural pad model.
module tb_nes_joypad_port;
    logic        clk = 1'b0, reset = 1'b1, ce = 1'b0, mr = 1'b0, mw = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  wdata = 8'h0;
    logic [7:0]  rdata;
    logic        rdata_en, pad_latch, pad_clk;
    logic [1:0]  pad_data;
    logic [7:0]  pad1 = 8'hFF, pad2 = 8'hFF, sr1 = 8'hFF, sr2 = 8'hFF;
    logic [7:0]  seq1 [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    // 4021-style pad: parallel load while latched, next bit presented on each falling pad_clk
    assign pad_data = {sr2[0], sr1[0]};
    always @(posedge pad_latch or negedge pad_clk) begin
        if (pad_latch) begin
            sr1 <= pad1;
            sr2 <= pad2;
        end else begin
            sr1 <= {1'b1, sr1[7:1]};
            sr2 <= {1'b1, sr2[7:1]};
        end
    end

    nes_joypad_port #(.CLK_DIV(4), .POLL_CYCLES(16'd40)) dut (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .wdata(wdata), .mr(mr), .mw(mw),
        .rdata(rdata), .rdata_en(rdata_en), .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_lvl(input bit on_clk, input logic lvl, input string tag);
        int n = 0;
        while (((on_clk ? pad_clk : pad_latch) !== lvl) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " timeout"}, 16'(n >= 2000), 16'd0);
    endtask

    task automatic wait_poll(input string tag);
        wait_lvl(1'b0, 1'b0, tag);
        wait_lvl(1'b0, 1'b1, tag);
    endtask

    task automatic wr_port(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk) begin addr = a; wdata = d; mw = 1'b1; ce = 1'b1; end
        @(negedge clk) begin mw = 1'b0; ce = 1'b0; end
    endtask

    task automatic rd_port(input logic [15:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk) begin addr = a; mr = 1'b1; ce = 1'b1; end
        @(negedge clk) begin mr = 1'b0; ce = 1'b0; end
        check({tag, " data"}, 16'(rdata), 16'(exp));
        check({tag, " en"}, 16'(rdata_en), 16'd1);
        @(negedge clk) ce = 1'b1;
        @(negedge clk) ce = 1'b0;
        check({tag, " en_drop"}, 16'(rdata_en), 16'd0);
    endtask

    function automatic logic [7:0] exp_bit(input logic [7:0] snap, input int i);
        return 8'h40 | {7'b0, i < 8 ? snap[i] : 1'b1};
    endfunction

    initial begin
        int n;
        pad1 = 8'hFE;
        pad2 = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst rdata", 16'(rdata), 16'h0);
        check("rst rdata_en", 16'(rdata_en), 16'h0);
        check("rst pad_latch", 16'(pad_latch), 16'h0);
        check("rst pad_clk", 16'(pad_clk), 16'h1);
        check("rst snap1", 16'(dut.u_poll.snap1), 16'h0);
        check("rst snap2", 16'(dut.u_poll.snap2), 16'h0);
        reset = 1'b0;

        wait_lvl(1'b0, 1'b1, "latch rise");
        n = 0;
        while (pad_latch && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("latch width", 16'(n), 16'd8);
        wait_lvl(1'b0, 1'b1, "poll1");
        check("poll1 snap1", 16'(dut.u_poll.snap1), 16'h01);
        check("poll1 snap2", 16'(dut.u_poll.snap2), 16'h00);

        pad1 = 8'hF6;
        pad2 = 8'h7F;
        wait_poll("poll2a");
        wait_poll("poll2b");
        wr_port(16'h4016, 8'h01);
        wr_port(16'h4016, 8'h00);
        for (int i = 0; i < 10; i++) rd_port(16'h4016, seq1[i], $sformatf("seq1[%0d]", i));

        wr_port(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) rd_port(16'h4017, 8'h40, $sformatf("strobe p2[%0d]", i));
        rd_port(16'h4016, 8'h41, "strobe p1");

        wr_port(16'h4016, 8'h00);
        for (int i = 0; i < 9; i++) begin
            rd_port(16'h4016, exp_bit(8'h09, i), $sformatf("ilv p1[%0d]", i));
            rd_port(16'h4017, exp_bit(8'h80, i), $sformatf("ilv p2[%0d]", i));
        end

        wr_port(16'h4016, 8'h01);
        wr_port(16'h4016, 8'h00);
        rd_port(16'h4016, 8'h41, "w4017 pre0");
        rd_port(16'h4016, 8'h40, "w4017 pre1");
        wr_port(16'h4017, 8'h01);
        @(negedge clk) begin addr = 16'h4016; mr = 1'b1; ce = 1'b0; end
        @(negedge clk) mr = 1'b0;
        rd_port(16'h4016, 8'h40, "w4017 post2");
        rd_port(16'h4016, 8'h41, "w4017 post3");

        wait_lvl(1'b0, 1'b1, "rst poll latch");
        wait_lvl(1'b0, 1'b0, "rst poll shift");
        for (int k = 1; k <= 4; k++) begin
            wait_lvl(1'b1, 1'b0, "bit lo");
            if (k < 4) wait_lvl(1'b1, 1'b1, "bit hi");
        end
        reset = 1'b1;
        addr = 16'h4016;
        mr = 1'b1;
        ce = 1'b1;
        @(negedge clk) begin reset = 1'b0; mr = 1'b0; ce = 1'b0; end
        check("midrst pad_clk", 16'(pad_clk), 16'h1);
        check("midrst pad_latch", 16'(pad_latch), 16'h0);
        check("midrst snap1", 16'(dut.u_poll.snap1), 16'h0);
        check("midrst snap2", 16'(dut.u_poll.snap2), 16'h0);
        check("midrst rdata_en", 16'(rdata_en), 16'h0);
        @(negedge clk);
        check("fresh latch", 16'(pad_latch), 16'h1);
        wait_poll("fresh poll");
        check("fresh snap1", 16'(dut.u_poll.snap1), 16'h09);
        check("fresh snap2", 16'(dut.u_poll.snap2), 16'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
